// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
package loader_pkg;

  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;
  localparam int BYTES  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: shifts bytes in MSB first and flags the
// 4th byte of a word so the loader can schedule the memory write.
module word_assembler
  import loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    shift_en,
  input  logic [BYTE_W-1:0]       in_byte,
  output logic [BYTES*BYTE_W-1:0] word,
  output logic                    word_full
);

  logic [1:0] idx;

  // Shift register and byte index; the index wraps after the 4th byte.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      word <= '0;
      idx  <= '0;
    end else if (shift_en) begin
      word <= {word[(BYTES-1)*BYTE_W-1:0], in_byte};
      idx  <= idx + 2'd1;
    end
  end

  // High while the next accepted byte completes the word.
  assign word_full = (idx == 2'd3);

endmodule

// File: rtl/inst_mem_loader.sv
// Boot loader: takes a length-prefixed byte stream, assembles 32-bit
// instructions and writes them to consecutive instruction-memory words,
// keeping the CPU in reset until the whole program is in place.
module inst_mem_loader #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  import loader_pkg::*;

  localparam int MAX_WORDS = 2**ADDR_W;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   full_len;
  logic [LEN_W-1:0]   cnt_inc_ext;
  logic [ADDR_W:0]    cnt_inc;
  logic [WORD_W-1:0]  asm_word;
  logic               asm_full;
  logic               asm_clr;
  logic               asm_shift;
  logic               xfer;

  // in_ready is a flop that mirrors "state accepts bytes", so it is safe to
  // qualify transfers with it directly.
  assign xfer        = in_valid & in_ready;
  assign full_len    = {len_q[LEN_W-1:8], in_byte};
  assign cnt_inc     = word_count + 1'b1;
  assign cnt_inc_ext = {{(LEN_W-ADDR_W-1){1'b0}}, cnt_inc};

  word_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .shift_en  (asm_shift),
    .in_byte   (in_byte),
    .word      (asm_word),
    .word_full (asm_full)
  );

  // Next-state logic and assembler controls.
  always_comb begin
    state_d   = state_q;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LEN_HI;
      S_LEN_HI: if (xfer)  state_d = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        asm_clr = 1'b1;
        if (full_len == '0)                         state_d = S_DONE;
        else if (full_len > LEN_W'(MAX_WORDS))      state_d = S_ERROR;
        else                                        state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        asm_shift = 1'b1;
        if (asm_full) state_d = S_WRITE;
      end
      S_WRITE:  state_d = (cnt_inc_ext == len_q) ? S_DONE : S_DATA;
      S_DONE,
      S_ERROR:  if (start) state_d = S_LEN_HI;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs decoded from the next state so
  // every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_count <= '0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_ready <= (state_d == S_LEN_HI) || (state_d == S_LEN_LO) || (state_d == S_DATA);
      wr_en    <= (state_d == S_WRITE);
      cpu_hold <= (state_d != S_DONE);
      done     <= (state_d == S_DONE);
      load_err <= (state_d == S_ERROR);

      if (state_q == S_LEN_HI && xfer) len_q[LEN_W-1:8] <= in_byte;
      if (state_q == S_LEN_LO && xfer) begin
        len_q      <= full_len;
        word_count <= '0;
      end
      // Capture the completed word including the byte arriving this cycle.
      if (state_q == S_DATA && state_d == S_WRITE) begin
        wr_addr <= word_count[ADDR_W-1:0];
        wr_data <= {asm_word[WORD_W-9:0], in_byte};
      end
      if (state_q == S_WRITE) word_count <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [7:0]  in_byte;
  logic        in_ready, wr_en, cpu_hold, done, load_err;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [8:0]  word_count;

  int tests = 0;
  int fails = 0;

  logic [7:0]  q_addr[$];
  logic [31:0] q_data[$];

  inst_mem_loader #(.WORD_W(32), .ADDR_W(8), .LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  // Record every memory write; wr_en is one cycle wide so each is seen once.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      q_addr.push_back(wr_addr);
      q_data.push_back(wr_data);
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_byte  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      tests++; fails++;
      $display("FAIL send_byte_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (done !== 1'b1 && load_err !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 50) begin
      fails++;
      $display("FAIL wait_end_timeout: done=%b load_err=%b required end of load", done, load_err);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({cpu_hold, in_ready, wr_en, done, load_err} !== 5'b10000 || word_count !== 9'd0) begin
      fails++;
      $display("FAIL reset: hold/rdy/wen/done/err=%b cnt=%0d required 10000 cnt=0",
               {cpu_hold, in_ready, wr_en, done, load_err}, word_count);
    end
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] s [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    clear_log();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i], 0);
      if (i == 5) begin
        @(negedge clk);
        tests++;
        if (wr_en !== 1'b1 || in_ready !== 1'b0 || wr_data !== 32'h20080005) begin
          fails++;
          $display("FAIL basic_latency: wr_en=%b in_ready=%b data=%h required 1 0 20080005",
                   wr_en, in_ready, wr_data);
        end
      end
    end
    wait_end();
    tests++;
    if (q_addr.size() != 2 || q_addr[0] !== 8'd0 || q_data[0] !== 32'h20080005 ||
        q_addr[1] !== 8'd1 || q_data[1] !== 32'h01095020) begin
      fails++;
      $display("FAIL basic_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 20080005 1 01095020",
               q_addr.size(), q_addr[0], q_data[0], q_addr[1], q_data[1]);
    end
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || word_count !== 9'd2) begin
      fails++;
      $display("FAIL basic_done: done=%b hold=%b cnt=%0d required 1 0 2", done, cpu_hold, word_count);
    end
  endtask

  task automatic test_stalls();
    logic [7:0] s [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    clear_log();
    pulse_start();
    tests++;
    if (done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL restart: done=%b hold=%b rdy=%b required 0 1 1", done, cpu_hold, in_ready);
    end
    for (int i = 0; i < 10; i++) begin
      send_byte(s[i], i % 4);
      if (i == 3) pulse_start();  // ignored mid-load
    end
    wait_end();
    tests++;
    if (q_addr.size() != 2 || q_addr[0] !== 8'd0 || q_data[0] !== 32'h20080005 ||
        q_addr[1] !== 8'd1 || q_data[1] !== 32'h01095020) begin
      fails++;
      $display("FAIL stall_writes: n=%0d a0=%0d d0=%h a1=%0d d1=%h required 2 0 20080005 1 01095020",
               q_addr.size(), q_addr[0], q_data[0], q_addr[1], q_data[1]);
    end
    tests++;
    if (done !== 1'b1 || word_count !== 9'd2) begin
      fails++;
      $display("FAIL stall_done: done=%b cnt=%0d required 1 2", done, word_count);
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || word_count !== 9'd0) begin
      fails++;
      $display("FAIL zero_len: done=%b hold=%b rdy=%b cnt=%0d required 1 0 0 0",
               done, cpu_hold, in_ready, word_count);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q_addr.size() != 0) begin
      fails++;
      $display("FAIL zero_len_writes: n=%0d required 0", q_addr.size());
    end
  endtask

  task automatic test_error();
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge clk);
    tests++;
    if (load_err !== 1'b1 || cpu_hold !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL err_flag: err=%b hold=%b rdy=%b done=%b required 1 1 0 0",
               load_err, cpu_hold, in_ready, done);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (q_addr.size() != 0 || load_err !== 1'b1) begin
      fails++;
      $display("FAIL err_hold: writes=%0d err=%b required 0 1", q_addr.size(), load_err);
    end
    pulse_start();
    tests++;
    if (load_err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL err_clear: err=%b rdy=%b required 0 1", load_err, in_ready);
    end
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hDE, 0); send_byte(8'hAD, 1); send_byte(8'hBE, 0); send_byte(8'hEF, 2);
    wait_end();
    tests++;
    if (done !== 1'b1 || load_err !== 1'b0 || q_addr.size() != 1 ||
        q_addr[0] !== 8'd0 || q_data[0] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL err_recover: done=%b err=%b n=%0d a=%0d d=%h required 1 0 1 0 deadbeef",
               done, load_err, q_addr.size(), q_addr[0], q_data[0]);
    end
  endtask

  task automatic test_abort();
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    tests++;
    if ({cpu_hold, in_ready, wr_en, done, load_err} !== 5'b10000 || word_count !== 9'd0 ||
        wr_data !== 32'd0 || wr_addr !== 8'd0) begin
      fails++;
      $display("FAIL abort_reset: hold/rdy/wen/done/err=%b cnt=%0d a=%0d d=%h required 10000 0 0 0",
               {cpu_hold, in_ready, wr_en, done, load_err}, word_count, wr_addr, wr_data);
    end
    rst = 1'b0;
    clear_log();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hA1, 0); send_byte(8'hB2, 0); send_byte(8'hC3, 0); send_byte(8'hD4, 0);
    wait_end();
    tests++;
    if (q_addr.size() != 1 || q_addr[0] !== 8'd0 || q_data[0] !== 32'hA1B2C3D4 || word_count !== 9'd1) begin
      fails++;
      $display("FAIL abort_reload: n=%0d a=%0d d=%h cnt=%0d required 1 0 a1b2c3d4 1",
               q_addr.size(), q_addr[0], q_data[0], word_count);
    end
  endtask

  task automatic test_max_len();
    int bad;
    clear_log();
    pulse_start();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    for (int w = 0; w < 256; w++) begin
      send_byte(8'(w), 0);
      send_byte(8'(~w), 0);
      send_byte(8'h5A ^ 8'(w), 0);
      send_byte(8'hC3, 0);
    end
    wait_end();
    tests++;
    if (done !== 1'b1 || load_err !== 1'b0 || word_count !== 9'd256 || q_addr.size() != 256) begin
      fails++;
      $display("FAIL max_done: done=%b err=%b cnt=%0d n=%0d required 1 0 256 256",
               done, load_err, word_count, q_addr.size());
    end
    bad = 0;
    for (int w = 0; w < q_addr.size(); w++)
      if (q_addr[w] !== 8'(w) || q_data[w] !== {8'(w), 8'(~w), 8'h5A ^ 8'(w), 8'hC3}) bad++;
    tests++;
    if (bad != 0 || q_addr.size() != 256 || q_addr[255] !== 8'd255) begin
      fails++;
      $display("FAIL max_writes: bad=%0d n=%0d required 0 256", bad, q_addr.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    test_reset();
    test_basic();
    test_stalls();
    test_zero_len();
    test_error();
    test_abort();
    test_max_len();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
